// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and width-derivation helpers for the width-converting FIFO.
`default_nettype none

package fifo_pkg;

  typedef enum logic {
    LANE_LSB_FIRST = 1'b0,
    LANE_MSB_FIRST = 1'b1
  } lane_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(value)) r = r + 1;
    end
    return r;
  endfunction

  function automatic int unit_w(input int wr_w, input int rd_w);
    return (wr_w < rd_w) ? wr_w : rd_w;
  endfunction

  function automatic int wu_of(input int wr_w, input int rd_w);
    return wr_w / unit_w(wr_w, rd_w);
  endfunction

  function automatic int ru_of(input int wr_w, input int rd_w);
    return rd_w / unit_w(wr_w, rd_w);
  endfunction

  function automatic int cw_of(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wconv_mem.sv
// +--------------------------------------------------------------------+
// | fifo_wconv_mem: unit-addressed storage, WU-unit write, RU-unit read |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module fifo_wconv_mem #(
  parameter int UNIT  = 8,
  parameter int DEPTH = 1024,
  parameter int WU    = 2,
  parameter int RU    = 1,
  parameter int AW    = 10
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [WU*UNIT-1:0] i_wdata,
  input  logic [AW-1:0]      i_raddr,
  output logic [RU*UNIT-1:0] o_rdata
);

  logic [UNIT-1:0] r_mem [DEPTH];

  // Unit i of the word (time order) lands at address + i.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < WU; i++) begin
        r_mem[i_waddr + AW'(i)] <= i_wdata[i*UNIT +: UNIT];
      end
    end
  end

  for (genvar g = 0; g < RU; g++) begin : g_rd
    assign o_rdata[g*UNIT +: UNIT] = r_mem[i_raddr + AW'(g)];
  end

endmodule

`default_nettype wire

// File: rtl/fifo_wconv_sync.sv
// +--------------------------------------------------------------------+
// | fifo_wconv_sync: single-clock FIFO with power-of-two width ratio    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module fifo_wconv_sync
  import fifo_pkg::*;
#(
  parameter int WR_W      = 16,
  parameter int RD_W      = 8,
  parameter int DEPTH     = 1024,
  parameter bit MSB_FIRST = 1'b1,
  parameter int AF_THR    = DEPTH - 16,
  parameter int AE_THR    = 16
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      Flush,
  input  logic [WR_W-1:0]           Din,
  input  logic                      Wen,
  output logic                      Full,
  output logic                      AlmostFull,
  input  logic                      Ren,
  output logic [RD_W-1:0]           Dout,
  output logic                      Dvalid,
  output logic                      Empty,
  output logic                      AlmostEmpty,
  output logic [cw_of(DEPTH)-1:0]   Count,
  output logic                      Ovf,
  output logic                      Udf
);

  localparam int UNIT = unit_w(WR_W, RD_W);
  localparam int WU   = wu_of(WR_W, RD_W);
  localparam int RU   = ru_of(WR_W, RD_W);
  localparam int AW   = clog2(DEPTH);
  localparam int CW   = AW + 1;

  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [RD_W-1:0] r_dout;
  logic            r_dvalid;
  logic            r_ovf;
  logic            r_udf;

  logic            w_full;
  logic            w_empty;
  logic            w_wr_acc;
  logic            w_rd_acc;
  logic [CW-1:0]   w_free;
  logic [WR_W-1:0] w_wdata;
  logic [RD_W-1:0] w_rdata;
  logic [RD_W-1:0] w_rd_packed;

  assign w_free   = CW'(DEPTH) - r_count;
  assign w_full   = w_free < CW'(WU);
  assign w_empty  = r_count < CW'(RU);
  assign w_wr_acc = Wen && !w_full && !Flush && !Rst;
  assign w_rd_acc = Ren && !w_empty && !Flush && !Rst;

  // Reorder between bus lanes and time-ordered units.
  always_comb begin
    w_wdata     = '0;
    w_rd_packed = '0;
    for (int i = 0; i < WU; i++) begin
      if (MSB_FIRST == LANE_MSB_FIRST) w_wdata[i*UNIT +: UNIT] = Din[WR_W-1-i*UNIT -: UNIT];
      else                             w_wdata[i*UNIT +: UNIT] = Din[i*UNIT +: UNIT];
    end
    for (int i = 0; i < RU; i++) begin
      if (MSB_FIRST == LANE_MSB_FIRST) w_rd_packed[RD_W-1-i*UNIT -: UNIT] = w_rdata[i*UNIT +: UNIT];
      else                             w_rd_packed[i*UNIT +: UNIT]        = w_rdata[i*UNIT +: UNIT];
    end
  end

  fifo_wconv_mem #(
    .UNIT  (UNIT),
    .DEPTH (DEPTH),
    .WU    (WU),
    .RU    (RU),
    .AW    (AW)
  ) u_mem (
    .clk     (Clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_dout   <= '0;
      r_dvalid <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (Flush) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_dvalid <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_dvalid <= w_rd_acc;
      if (w_wr_acc) r_wptr <= r_wptr + AW'(WU);
      if (w_rd_acc) begin
        r_rptr <= r_rptr + AW'(RU);
        r_dout <= w_rd_packed;
      end
      r_count <= r_count + (w_wr_acc ? CW'(WU) : CW'(0)) - (w_rd_acc ? CW'(RU) : CW'(0));
      if (Wen && w_full)  r_ovf <= 1'b1;
      if (Ren && w_empty) r_udf <= 1'b1;
    end
  end

  assign Full        = w_full;
  assign Empty       = w_empty;
  assign AlmostFull  = r_count >= CW'(AF_THR);
  assign AlmostEmpty = r_count <= CW'(AE_THR);
  assign Count       = r_count;
  assign Dout        = r_dout;
  assign Dvalid      = r_dvalid;
  assign Ovf         = r_ovf;
  assign Udf         = r_udf;

endmodule

`default_nettype wire

// File: doc/fifo_wconv_sync.md
Name: fifo_wconv_sync

Overview:
- Single-clock FIFO with independent write and read widths. Generalises the fixed 1024x8 FIFO with 16-bit write and 8-bit read to any power-of-two width ratio, in either direction.
- Adds configurable lane order, almost-full/almost-empty thresholds, a fill count, synchronous flush, and sticky overflow/underflow flags.
- Sits between a packet/data producer and the SDRAM controller datapath, where both run on the controller clock.

Parameters:
- WR_W, 16, write data width in bits.
- RD_W, 8, read data width in bits.
- DEPTH, 1024, capacity in units. One unit is UNIT = min(WR_W, RD_W) bits. Must be a power of 2.
- MSB_FIRST, 1, lane order. 1 = most-significant unit is first in time; 0 = least-significant unit is first in time.
- AF_THR, DEPTH-16, AlmostFull threshold in units.
- AE_THR, 16, AlmostEmpty threshold in units.
- Derived values:
  - WU = WR_W/UNIT, RU = RD_W/UNIT. Either WU or RU equals 1; the other is a power of 2.
  - CW = clog2(DEPTH)+1.
  - DEPTH must be a multiple of max(WU, RU).

Ports:
- Clk, in, 1, sole clock; rising edge.
- Rst, in, 1, synchronous active-high reset.
- Flush, in, 1, synchronous clear of contents and flags.
- Din, in, WR_W, write data.
- Wen, in, 1, write request.
- Full, out, 1, cannot accept WU more units.
- AlmostFull, out, 1, Count >= AF_THR.
- Ren, in, 1, read request.
- Dout, out, RD_W, registered read data.
- Dvalid, out, 1, Dout updated this cycle.
- Empty, out, 1, fewer than RU units stored.
- AlmostEmpty, out, 1, Count <= AE_THR.
- Count, out, CW, stored units.
- Ovf, out, 1, sticky: a write was attempted while Full.
- Udf, out, 1, sticky: a read was attempted while Empty.

Behaviour:
- Interface (decided): one clock, Clk. Reset Rst is synchronous and active-high. No asynchronous logic.
- Reset values:
  - Dout=0, Dvalid=0, Count=0, Ovf=0, Udf=0.
  - Empty=1, Full=0, AlmostEmpty=1.
  - AlmostFull = (AF_THR==0).
- Storage is a circular array of DEPTH units with wrapping write and read pointers (clog2(DEPTH) bits each).
- Flag derivation: Full = (DEPTH-Count) < WU; Empty = Count < RU. Flags are combinational from the registered Count, so they change the cycle after the accepting edge.
- Write accept:
  - Condition: Wen && !Full at the edge.
  - Din is split into WU units, stored at wptr .. wptr+WU-1, and wptr advances by WU.
  - MSB_FIRST=1: Din[WR_W-1 -: UNIT] is stored first.
- Read accept:
  - Condition: Ren && !Empty at the edge.
  - RU units from rptr are packed into Dout at that edge; Dvalid=1 for the next cycle; rptr advances by RU.
  - MSB_FIRST=1: the first unit goes to Dout[RD_W-1 -: UNIT].
- Read latency is 1 cycle (Ren edge to Dout/Dvalid). Dout holds its value when no read is accepted; Dvalid=0 in that case.
- Simultaneous accepted read and write: Count <= Count + WU - RU. Full and Empty use the pre-edge Count; there is no look-ahead.
- Rejected requests:
  - Wen && Full: data dropped, Ovf <= 1.
  - Ren && Empty: Dout unchanged, Dvalid=0, Udf <= 1.
  - Ovf and Udf clear only on Rst or Flush.
- Flush:
  - Pointers, Count, Ovf and Udf go to 0; Dvalid goes to 0. Dout is unchanged.
  - Flush overrides Wen and Ren in the same cycle.
- Rst mid-operation behaves like Flush and also zeroes Dout. Rst has priority over everything.
- Pointer wrap is natural modulo DEPTH. A multi-unit access never straddles the wrap because DEPTH is a multiple of max(WU, RU).

Decomposition:
- Shared package fifo_pkg holds:
  - the clog2 constant function;
  - the UNIT/WU/RU/CW derivation as localparam helpers;
  - lane-order enum constants LANE_MSB_FIRST=1 and LANE_LSB_FIRST=0.
- One sub-module, fifo_wconv_mem: unit-addressed register/RAM array with a WU-unit write port and an RU-unit read port.
- Pointers, Count, flags and packing stay in the top module.

Test Plan:
- Reset: hold Rst 2 cycles with Wen=Ren=1 -> Count=0, Empty=1, Full=0, Dout=0, Ovf=Udf=0.
- Downsize with defaults:
  - Write 16'h0A0F -> Count=2.
  - Ren for 2 cycles -> Dout=8'h0A then 8'h0F, each with Dvalid the following cycle; Count 2->1->0.
  - With MSB_FIRST=0 the order is 0F then 0A.
- Fill and wrap with defaults:
  - 512 writes of k*16'h0101 -> Full=1, Count=1024.
  - 513th write dropped, Ovf=1.
  - Read 1024 bytes -> exact order, Empty=1.
  - Repeat the cycle twice to cross the pointer wrap.
- Upsize with WR_W=8, RD_W=32, MSB_FIRST=0:
  - Write 11, 22, 33 -> Empty stays 1, Count=3.
  - Write 44, then Ren -> Dout=32'h44332211.
  - Ren while Empty -> Udf=1, Dout held.
- Simultaneous access with defaults at Count=2: Wen & Ren together -> Count=3. At Count=1022, Wen & Ren together -> write accepted, Count=1023.
- Flush/Rst mid-stream:
  - At Count=600 with Wen=1 and Ovf=1, Flush -> Count=0, Empty=1, Ovf=0, Dout kept.
  - Same scenario with Rst -> Dout=0.
